reg_pipe_chain: RTL and testbench

- Parametrised elastic register pipeline: WIDTH-bit data, DEPTH stages, valid/ready handshake on both sides.
- Applies a selectable per-word transform (pass, invert, saturating increment, bit-reverse) at the input stage.
- Provides a transfer counter and a synchronous flush.
- Successor to the fixed single-bit registered-input / function stage used between top-level input pins and SUB-type consumers.

---
 rtl/reg_pipe_chain.sv | 86 ++++++++
 tb/tb_reg_pipe_chain.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe_chain.sv
// Elastic register pipeline with valid/ready handshake on both ends, a per-word
// transform applied at the input stage, a saturating transfer counter and a flush.
module reg_pipe_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic [1:0]       MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [CNT_W-1:0] XFER_CNT
);

  logic [DEPTH-1:0] stage_valid_reg;
  logic [WIDTH-1:0] stage_data_reg [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [CNT_W-1:0] xfer_cnt_reg;
  logic             in_fire;
  logic             out_fire;

  function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] x, input logic [1:0] m);
    logic [WIDTH-1:0] r;
    r = x;
    case (m)
      2'd0: r = x;
      2'd1: r = ~x;
      2'd2: r = (&x) ? x : x + WIDTH'(1);
      2'd3: for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
      default: r = x;
    endcase
    return r;
  endfunction

  // A stage can take a word if it is empty or its own word is moving on.
  assign rdy[DEPTH-1] = !stage_valid_reg[DEPTH-1] | OUT_READY;
  for (genvar gi = 0; gi < DEPTH - 1; gi++) begin : g_rdy
    assign rdy[gi] = !stage_valid_reg[gi] | rdy[gi+1];
  end

  assign in_fire   = IN_VALID & rdy[0];
  assign out_fire  = stage_valid_reg[DEPTH-1] & OUT_READY;
  assign IN_READY  = rdy[0];
  assign OUT_VALID = stage_valid_reg[DEPTH-1];
  assign OUT_DATA  = stage_data_reg[DEPTH-1];
  assign XFER_CNT  = xfer_cnt_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stage_valid_reg <= '0;
      for (int k = 0; k < DEPTH; k++) stage_data_reg[k] <= '0;
    end else begin
      if (FLUSH) begin
        stage_valid_reg[0] <= 1'b0;
      end else if (rdy[0]) begin
        stage_valid_reg[0] <= IN_VALID;
      end
      if (in_fire) stage_data_reg[0] <= xform(IN_DATA, MODE);

      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          stage_valid_reg[k] <= FLUSH ? 1'b0 : stage_valid_reg[k-1];
          stage_data_reg[k]  <= stage_data_reg[k-1];
        end else if (FLUSH) begin
          stage_valid_reg[k] <= 1'b0;
        end
      end
    end
  end

  // Output handshakes still count when they coincide with a flush.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      xfer_cnt_reg <= '0;
    end else if (out_fire && !(&xfer_cnt_reg)) begin
      xfer_cnt_reg <= xfer_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_pipe_chain.sv
// Bench for reg_pipe_chain: a queue model of word positions checked every cycle,
// plus directed vectors with hand-computed results; a CNT_W=3 copy shares the stimulus.
module tb_reg_pipe_chain;
  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, in_ready_s, out_valid_s;
  logic [W-1:0] out_data, out_data_s;
  logic [15:0]  xfer_cnt;
  logic [2:0]   xfer_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  reg_pipe_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .FLUSH(flush), .MODE(mode),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
    .XFER_CNT(xfer_cnt)
  );

  reg_pipe_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(3)) dut_s (
    .CLK(clk), .RST(rst), .FLUSH(flush), .MODE(mode),
    .IN_VALID(in_valid), .IN_READY(in_ready_s), .IN_DATA(in_data),
    .OUT_VALID(out_valid_s), .OUT_READY(out_ready), .OUT_DATA(out_data_s),
    .XFER_CNT(xfer_cnt_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] f_model(input logic [W-1:0] x, input logic [1:0] m);
    logic [W-1:0] r;
    case (m)
      2'd0: r = x;
      2'd1: r = 8'hFF - x;
      2'd2: r = (x == 8'hFF) ? x : x + 8'd1;
      default: for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    endcase
    return r;
  endfunction

  // Model: ordered words with their stage position; a word advances unless the
  // output is stalled and every stage ahead of it is occupied.
  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } word_t;
  word_t q[$];
  word_t tmp;
  int    m_cnt = 0;
  int    m_cnt_s = 0;
  bit    m_out_fire, m_in_fire;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_cnt = 0;
      m_cnt_s = 0;
    end else begin
      cyc++;
      m_out_fire = (q.size() > 0) && (q[0].pos == D - 1) && out_ready;
      m_in_fire  = in_valid && ((q.size() < D) || out_ready);
      if (m_out_fire) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 7) m_cnt_s++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (m_out_fire) void'(q.pop_front());
        for (int j = 0; j < q.size(); j++) begin
          tmp = q[j];
          if (out_ready || (j < D - 1 - tmp.pos)) tmp.pos++;
          q[j] = tmp;
        end
        if (m_in_fire) begin
          tmp.data = f_model(in_data, mode);
          tmp.pos  = 0;
          q.push_back(tmp);
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus an output-handshake log.
  logic [W-1:0] out_log[$];
  int           out_cyc[$];
  bit           exp_ov;

  always @(negedge clk) begin
    if (rst) begin
      exp_ov = (q.size() > 0) && (q[0].pos == D - 1);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < D) || out_ready});
      if (exp_ov) chk("out_data", {24'd0, out_data}, {24'd0, q[0].data});
      chk("xfer_cnt", {16'd0, xfer_cnt}, m_cnt);
      chk("xfer_cnt_small", {29'd0, xfer_cnt_s}, m_cnt_s);
      if (out_valid && out_ready) begin
        out_log.push_back(out_data);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [W-1:0] tv_data [9] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
  logic [1:0]   tv_mode [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
  logic [W-1:0] tv_exp  [9] = '{8'h81, 8'h7E, 8'h82, 8'h81, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h80};

  initial begin
    int t_in;
    int acc;

    // Reset and idle
    step(3);
    rst = 1'b1;
    step(2);
    @(negedge clk);
    chk("idle_out_valid", {31'd0, out_valid}, 0);
    chk("idle_out_data", {24'd0, out_data}, 0);
    chk("idle_in_ready", {31'd0, in_ready}, 1);
    chk("idle_xfer_cnt", {16'd0, xfer_cnt}, 0);
    @(posedge clk); #1;

    // Streaming 0x01..0x0A, MODE=0
    out_ready = 1'b1;
    out_log.delete(); out_cyc.delete();
    t_in = -100;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      @(negedge clk);
      if (i == 1) t_in = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    step(6);
    chk("stream_count", out_log.size(), 10);
    for (int k = 0; k < out_log.size() && k < 10; k++) begin
      chk("stream_data", {24'd0, out_log[k]}, k + 1);
      chk("stream_no_bubble", out_cyc[k], out_cyc[0] + k);
    end
    if (out_cyc.size() > 0) chk("stream_latency", out_cyc[0] - t_in, D);
    chk("stream_xfer_cnt", {16'd0, xfer_cnt}, 10);

    // Transforms, MODE changing every word
    out_log.delete(); out_cyc.delete();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = tv_data[i];
      mode     = tv_mode[i];
      step(1);
    end
    in_valid = 1'b0;
    mode = 2'd0;
    step(6);
    chk("xform_count", out_log.size(), 9);
    for (int k = 0; k < out_log.size() && k < 9; k++)
      chk("xform_data", {24'd0, out_log[k]}, {24'd0, tv_exp[k]});

    // Backpressure: offer 0x11.. with OUT_READY=0
    out_log.delete(); out_cyc.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_data = 8'h11 + W'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", acc, 3);
    @(negedge clk);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_out_data", {24'd0, out_data}, 8'h11);
    step(2);
    @(negedge clk);
    chk("bp_out_stable", {24'd0, out_data}, 8'h11);
    @(posedge clk); #1;

    // Full and simultaneous in/out handshake
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 1);
    chk("full_out_valid", {31'd0, out_valid}, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_data = 8'h15;
    @(negedge clk);
    chk("full_occupancy", {31'd0, in_ready}, 0);
    chk("full_next_data", {24'd0, out_data}, 8'h12);
    @(posedge clk); #1;
    out_ready = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(6);
    chk("bp_count", out_log.size(), 5);
    for (int k = 0; k < out_log.size() && k < 5; k++)
      chk("bp_order", {24'd0, out_log[k]}, 8'h11 + k);
    chk("bp_xfer_cnt", {16'd0, xfer_cnt}, 24);

    // Flush with two words in flight and an input offered the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h21; step(1);
    in_data = 8'h22; step(1);
    in_data = 8'h23; flush = 1'b1; step(1);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 0);
    chk("flush_xfer_cnt", {16'd0, xfer_cnt}, 24);
    step(4);
    @(negedge clk);
    chk("flush_discard", {31'd0, out_valid}, 0);
    @(posedge clk); #1;

    // Flush coinciding with an output handshake
    out_log.delete(); out_cyc.delete();
    in_valid = 1'b1; in_data = 8'h31; step(1);
    in_valid = 1'b0; step(2);
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_hs_valid", {31'd0, out_valid}, 1);
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("flush_hs_out_valid", {31'd0, out_valid}, 0);
    chk("flush_hs_cnt", {16'd0, xfer_cnt}, 25);
    chk("flush_hs_word", {24'd0, (out_log.size() > 0) ? out_log[0] : 8'h00}, 8'h31);
    @(posedge clk); #1;

    // Reset mid-flight
    in_valid = 1'b1;
    in_data = 8'h41; step(1);
    in_data = 8'h42; step(1);
    in_data = 8'h43; step(1);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_xfer_cnt", {16'd0, xfer_cnt}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    step(2);
    rst = 1'b1;
    step(1);

    // Counter saturation on the CNT_W=3 copy
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data = 8'h50 + W'(i);
      step(1);
    end
    in_valid = 1'b0;
    step(6);
    chk("sat_cnt_wide", {16'd0, xfer_cnt}, 9);
    chk("sat_cnt_small", {29'd0, xfer_cnt_s}, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
